// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants for the data-memory arbiter
//   DMEM_AW / DMEM_DW : default RAM word-address and data widths
//   PORT_CPU / PORT_DBG : port indices used for grant bookkeeping
package dmem_arb_pkg;
    localparam int   DMEM_AW  = 6;
    localparam int   DMEM_DW  = 32;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin picker producing a one-hot grant
//   req[1:0] : request per port
//   last     : port granted most recently; loses a tie
//   gnt[1:0] : one-hot grant, all-zero when nothing requests
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    assign gnt = (req == 2'b11) ? ((last == PORT_DBG) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter of CPU (port 0) and debug (port 1) onto the single-port data RAM
//   clk, rst                     : clock, synchronous active-high reset
//   mX_req/we/addr/wdata         : master request, held until an edge with mX_gnt
//   mX_gnt                       : combinational grant
//   mX_rvalid/rdata              : registered read return, one cycle after the read grant
//   ram_addr/we/wdata, ram_rdata : RAM drive (async read, sync write)
//   perf_gnt0/gnt1/conflict      : saturating counters, present only with DMEM_ARB_PERF_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_gnt0,
    output logic [CNT_W-1:0] perf_gnt1,
    output logic [CNT_W-1:0] perf_conflict
`endif
);
    logic       last_gnt;
    logic [1:0] req;
    logic [1:0] gnt;

    // requests are masked during reset so no grant (and no RAM write) can occur
    assign req = rst ? 2'b00 : {m1_req, m0_req};

    rr_arb2 u_rr (
        .req  (req),
        .last (last_gnt),
        .gnt  (gnt)
    );

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign ram_addr  = gnt[0] ? m0_addr  : gnt[1] ? m1_addr  : '0;
    assign ram_wdata = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : '0;
    assign ram_we    = (gnt[0] & m0_we) | (gnt[1] & m1_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt  <= PORT_DBG;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (|gnt) last_gnt <= gnt[1];
            m0_rvalid <= gnt[0] & ~m0_we;
            m1_rvalid <= gnt[1] & ~m1_we;
            if (gnt[0] & ~m0_we) m0_rdata <= ram_rdata;
            if (gnt[1] & ~m1_we) m1_rdata <= ram_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else begin
            if (gnt[0] && perf_gnt0 != '1) perf_gnt0 <= perf_gnt0 + CNT_W'(1);
            if (gnt[1] && perf_gnt1 != '1) perf_gnt1 <= perf_gnt1 + CNT_W'(1);
            if (m0_req && m1_req && perf_conflict != '1) perf_conflict <= perf_conflict + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural 64x32 RAM
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif
    logic [31:0] mem [64];
    int          n_cmp = 0;
    int          n_err = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
        mem[1]  = 32'h1111_1111;
        mem[2]  = 32'h2222_2222;
        mem[63] = 32'hA5A5_A5A5;
        mem[7]  = 32'h7777_7777;
        rst = 1'b1;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        cyc();
        cyc();
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd9; m1_wdata = 32'hBAD0_BAD0;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_ram_we", ram_we, 0);
`ifdef DMEM_ARB_PERF_EN
        chk("rst_perf_gnt0", perf_gnt0, 0);
        chk("rst_perf_conflict", perf_conflict, 0);
`endif
        cyc();
        chk("rst_no_write", mem[9], 32'h0909_0909);
        // continuous conflict right after reset: 0,1,0,1,0,1
        rst = 1'b0;
        m1_we = 1'b0; m0_addr = 6'd1; m1_addr = 6'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cf_m0_gnt", m0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("cf_m1_gnt", m1_gnt, (i % 2 == 0) ? 0 : 1);
            cyc();
            chk("cf_m0_rvalid", m0_rvalid, (i % 2 == 0) ? 1 : 0);
            chk("cf_m1_rvalid", m1_rvalid, (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) chk("cf_m0_rdata", m0_rdata, 32'h1111_1111);
            else chk("cf_m1_rdata", m1_rdata, 32'h2222_2222);
        end
        m0_req = 1'b0; m1_req = 1'b0;
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflict", perf_conflict, 6);
        chk("perf_gnt0", perf_gnt0, 3);
        chk("perf_gnt1", perf_gnt1, 3);
`endif
        // port 0 alone: write then read addr 5
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd5; m0_wdata = 32'hDEAD_BEEF;
        #1;
        chk("w5_m0_gnt", m0_gnt, 1);
        chk("w5_ram_we", ram_we, 1);
        chk("w5_ram_addr", ram_addr, 5);
        chk("w5_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        cyc();
        chk("w5_no_rvalid", m0_rvalid, 0);
        m0_we = 1'b0;
        #1;
        chk("r5_m0_gnt", m0_gnt, 1);
        chk("r5_ram_we", ram_we, 0);
        cyc();
        m0_req = 1'b0;
        chk("r5_m0_rvalid", m0_rvalid, 1);
        chk("r5_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        cyc();
        chk("r5_rvalid_pulse", m0_rvalid, 0);
        chk("r5_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
        // port 1 alone read, leaves last_gnt at port 1
        m1_req = 1'b1; m1_addr = 6'd2;
        #1;
        chk("p1_m1_gnt", m1_gnt, 1);
        cyc();
        m1_req = 1'b0;
        chk("p1_m1_rvalid", m1_rvalid, 1);
        chk("p1_m1_rdata", m1_rdata, 32'h2222_2222);
        // same-address conflict on 63: port 0 reads old data, port 1 writes next
        m0_req = 1'b1; m0_addr = 6'd63;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd63; m1_wdata = 32'h1234_5678;
        #1;
        chk("a63_m0_gnt", m0_gnt, 1);
        chk("a63_m1_gnt0", m1_gnt, 0);
        chk("a63_ram_addr", ram_addr, 63);
        chk("a63_ram_we0", ram_we, 0);
        cyc();
        m0_req = 1'b0;
        chk("a63_old_rdata", m0_rdata, 32'hA5A5_A5A5);
        chk("a63_m0_rvalid", m0_rvalid, 1);
        #1;
        chk("a63_m1_gnt", m1_gnt, 1);
        chk("a63_ram_we", ram_we, 1);
        cyc();
        m1_req = 1'b0; m1_we = 1'b0;
        chk("a63_m1_no_rvalid", m1_rvalid, 0);
        m0_req = 1'b1;
        cyc();
        m0_req = 1'b0;
        chk("a63_new_rdata", m0_rdata, 32'h1234_5678);
        // idle: no RAM activity, last_gnt (port 0) held
        #1;
        chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_wdata", ram_wdata, 0);
        chk("idle_m0_gnt", m0_gnt, 0);
        chk("idle_m1_gnt", m1_gnt, 0);
        cyc();
        cyc();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 6'd1; m1_addr = 6'd2;
        #1;
        chk("idle_hold_m1_gnt", m1_gnt, 1);
        chk("idle_hold_m0_gnt", m0_gnt, 0);
        cyc();
        m1_req = 1'b0;
        #1;
        chk("after_m0_gnt", m0_gnt, 1);
        cyc();
        m0_req = 1'b0;
        chk("pre_rst_rvalid", m0_rvalid, 1);
        // reset in the cycle after a granted read; pending write dropped
        rst = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd7; m1_wdata = 32'h0BAD_0BAD;
        #1;
        chk("mid_rst_ram_we", ram_we, 0);
        cyc();
        chk("mid_rst_rvalid", m0_rvalid, 0);
        chk("mid_rst_rdata", m0_rdata, 0);
        chk("mid_rst_no_write", mem[7], 32'h7777_7777);
        rst = 1'b0;
        m1_we = 1'b0; m0_req = 1'b1; m0_addr = 6'd7;
        #1;
        chk("post_rst_m0_gnt", m0_gnt, 1);
        chk("post_rst_m1_gnt", m1_gnt, 0);
        cyc();
        m0_req = 1'b0;
        chk("post_rst_m0_rdata", m0_rdata, 32'h7777_7777);
        #1;
        chk("post_rst_m1_gnt2", m1_gnt, 1);
        cyc();
        m1_req = 1'b0;
        chk("post_rst_m1_rdata", m1_rdata, 32'h7777_7777);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter for the single-port 64-word data RAM.
- Port 0: the CPU load/store path.
- Port 1: a debug/loader master that preloads or inspects data memory.
- Round-robin grant, at most one RAM access per cycle, registered read return.
- Sits between the masters and the RAM. The RAM keeps its async read and sync write.

Parameters:
AW, 6, word-address width (64 words)
DW, 32, data width
CNT_W, 16, width of performance counters (used only with DMEM_ARB_PERF_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_req  in  1  port-0 access request
m0_we  in  1  port-0 write (1) / read (0)
m0_addr  in  AW  port-0 word address
m0_wdata  in  DW  port-0 write data
m0_gnt  out  1  port-0 granted this cycle (combinational)
m0_rvalid  out  1  port-0 read data valid (registered)
m0_rdata  out  DW  port-0 read data (registered)
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
ram_addr  out  AW  RAM word address
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM async read data
perf_gnt0, perf_gnt1, perf_conflict  out  CNT_W  counters (DMEM_ARB_PERF_EN only)

Behaviour:
- Reset (sync, active-high):
  - m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0.
  - last_gnt = 1, so port 0 wins the first conflict.
  - Counters = 0.
- Grant logic (combinational, same cycle as request):
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port NOT equal to last_gnt.
  - No request: no grant.
  - gnt is asserted only while req is high. gnt is never asserted during rst.
- last_gnt updates at the clock edge to the granted port. It holds when no grant.
- Master rule: hold req, we, addr, wdata stable until a clock edge with gnt = 1. Deassert or change them only after that edge.
- RAM drive:
  - ram_addr, ram_wdata: muxed from the granted port.
  - ram_we = gnt & we of the granted port.
  - Idle: ram_addr = 0, ram_wdata = 0, ram_we = 0.
- Write: committed at the edge closing the grant cycle. No rvalid for writes.
- Read:
  - At the edge closing a granted read, mX_rdata <= ram_rdata and mX_rvalid <= 1 for exactly one cycle.
  - Latency 1 cycle after grant.
  - mX_rdata holds its last value when rvalid = 0.
- Back-to-back: a port may be granted every cycle if the other is idle. Under continuous conflict, grants alternate 0, 1, 0, 1, ...
- Same-address conflict:
  - Serialized by grant order.
  - A read granted the cycle after a write to the same address returns the new data.
- Reset mid-operation: a pending rvalid is dropped (0 next cycle). Writes not yet at an edge are not performed.
- Only port 0 is permitted to stall on !m0_gnt. The CPU integration freezes the PC while m0_req & !m0_gnt.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined:
  - perf_gnt0 and perf_gnt1 increment on each grant to that port.
  - perf_conflict increments each cycle both req are high.
  - All counters saturate at all-ones and clear on rst.
- Undefined: counter ports are omitted and no counter logic is built. Arbitration is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - DMEM_AW = 6 and DMEM_DW = 32 constants.
  - Port-index constants PORT_CPU = 0, PORT_DBG = 1.
- One natural sub-module: rr_arb2, a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - The last_gnt register is kept in the parent.

Test Plan:
- Reset: after rst, m0_rvalid = m1_rvalid = 0 and ram_we = 0 → the first conflict on the next cycle grants port 0.
- Port 0 alone writes 0xDEADBEEF to addr 5, then reads addr 5 → m0_gnt = 1 both cycles; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF one cycle after the read grant.
- Both request continuously for 6 cycles (port 0 reads addr 1, port 1 reads addr 2) → grant order 0, 1, 0, 1, 0, 1; each rvalid pulses only for its own grant. With PERF_EN: perf_conflict = 6, perf_gnt0 = 3, perf_gnt1 = 3.
- Port 1 writes 0x12345678 to addr 63 while port 0 requests a read of addr 63 → port 0 is granted first (old data); port 1 writes next cycle; a later port 0 read returns 0x12345678.
- Assert rst in the cycle after a granted read → m0_rvalid = 0 in the following cycle, and last_gnt is restored so the next conflict grants port 0.
- Idle cycles (no req) → ram_we = 0, ram_addr = 0, both gnt = 0, last_gnt unchanged.
